// File: rtl/regfile_16x32.sv
// rtl/regfile_16x32.sv - 16-entry register file with pending scoreboard and write-through reads
//
// Ports:
//   clock       in   single clock, all state updates on the rising edge
//   reset       in   synchronous, active-high
//   wr_en       in   write-back strobe
//   wr_sel      in   16-bit one-hot destination select
//   wr_data     in   write-back value
//   claim_en    in   issue strobe, marks claim_sel as pending
//   claim_sel   in   4-bit binary index of the claimed register
//   rd_a_sel    in   4-bit binary read index, port A
//   rd_b_sel    in   4-bit binary read index, port B
//   rd_a_data   out  registered read data, port A
//   rd_b_data   out  registered read data, port B
//   busy_a      out  pending bit of the register addressed by rd_a_sel
//   busy_b      out  pending bit of the register addressed by rd_b_sel
//   err_sel     out  sticky flag, set by a write with more than one wr_sel bit
module regfile_16x32 #(
  parameter int DATA_W  = 32,
  parameter int R0_ZERO = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [15:0]       wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [3:0]        claim_sel,
  input  logic [3:0]        rd_a_sel,
  input  logic [3:0]        rd_b_sel,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              busy_a,
  output logic              busy_b,
  output logic              err_sel
);

  logic [DATA_W-1:0] regs [16];
  logic [15:0]       pending;

  logic              sel_nonzero;
  logic              sel_onehot;
  logic              wr_multi;
  logic [15:0]       wr_mask;
  logic [15:0]       claim_mask;
  logic [DATA_W-1:0] rd_a_next;
  logic [DATA_W-1:0] rd_b_next;

  // wr_mask is the set of registers actually written this edge: empty for
  // no-op or illegal selects, and with register 0 removed when it is hardwired.
  always_comb begin
    sel_nonzero = |wr_sel;
    sel_onehot  = sel_nonzero && ((wr_sel & (wr_sel - 16'd1)) == 16'd0);
    wr_multi    = wr_en && sel_nonzero && !sel_onehot;
    wr_mask     = (wr_en && sel_onehot) ? wr_sel : 16'd0;
    claim_mask  = claim_en ? (16'd1 << claim_sel) : 16'd0;
    if (R0_ZERO != 0) begin
      wr_mask[0]    = 1'b0;
      claim_mask[0] = 1'b0;
    end
  end

  // Read muxes with write-through: a committing write to the addressed
  // register is forwarded so the registered output never shows stale data.
  always_comb begin
    rd_a_next = regs[rd_a_sel];
    if (wr_mask[rd_a_sel]) rd_a_next = wr_data;
    if (R0_ZERO != 0 && rd_a_sel == 4'd0) rd_a_next = '0;

    rd_b_next = regs[rd_b_sel];
    if (wr_mask[rd_b_sel]) rd_b_next = wr_data;
    if (R0_ZERO != 0 && rd_b_sel == 4'd0) rd_b_next = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      pending   <= '0;
      rd_a_data <= '0;
      rd_b_data <= '0;
      err_sel   <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (wr_mask[i]) regs[i] <= wr_data;
      end
      // Claim is applied after the write clear so a same-cycle claim wins.
      pending   <= (pending & ~wr_mask) | claim_mask;
      rd_a_data <= rd_a_next;
      rd_b_data <= rd_b_next;
      if (wr_multi) err_sel <= 1'b1;
    end
  end

  // No bypass: busy reflects only the registered pending vector.
  assign busy_a = pending[rd_a_sel];
  assign busy_b = pending[rd_b_sel];

endmodule

// File: tb/tb_regfile_16x32.sv
// tb/tb_regfile_16x32.sv - scoreboard bench for regfile_16x32
module tb_regfile_16x32;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_sel;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [3:0]  claim_sel;
  logic [3:0]  rd_a_sel;
  logic [3:0]  rd_b_sel;
  logic [31:0] rd_a_data;
  logic [31:0] rd_b_data;
  logic        busy_a;
  logic        busy_b;
  logic        err_sel;

  regfile_16x32 #(.DATA_W(32), .R0_ZERO(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .claim_en  (claim_en),
    .claim_sel (claim_sel),
    .rd_a_sel  (rd_a_sel),
    .rd_b_sel  (rd_b_sel),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .err_sel   (err_sel)
  );

  always #5 clock = ~clock;

  localparam int K_RDA = 0, K_RDB = 1, K_BSA = 2, K_BSB = 3, K_ERR = 4;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: at each falling edge, compare every expectation due this cycle.
  always @(negedge clock) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          K_RDA:   act = rd_a_data;
          K_RDB:   act = rd_b_data;
          K_BSA:   act = {31'd0, busy_a};
          K_BSB:   act = {31'd0, busy_b};
          default: act = {31'd0, err_sel};
        endcase
        n_cmp++;
        if (act !== sb[i].val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expectation visible now (combinational outputs, before the next edge).
  task automatic exp_now(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.due = cyc; e.kind = kind; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  // Expectation visible after the next rising edge.
  task automatic exp_next(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.due = cyc + 1; e.kind = kind; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_sel = 16'h0; wr_data = 32'h0;
    claim_en = 1'b0; claim_sel = 4'd0;
  endtask

  task automatic write(input logic [15:0] sel, input logic [31:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; idle(); rd_a_sel = 4'd0; rd_b_sel = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if (rd_a_data !== 32'h0) begin
      n_bad++;
      $display("FAIL direct_reset_rd_a: got %h expected %h", rd_a_data, 32'h0);
    end
    n_cmp++;
    if (rd_b_data !== 32'h0) begin
      n_bad++;
      $display("FAIL direct_reset_rd_b: got %h expected %h", rd_b_data, 32'h0);
    end
    n_cmp++;
    if (err_sel !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_reset_err: got %b expected %b", err_sel, 1'b0);
    end
    exp_now(K_RDA, 32'h0, "reset_rd_a");
    exp_now(K_RDB, 32'h0, "reset_rd_b");
    exp_now(K_BSA, 32'h0, "reset_busy_a");
    exp_now(K_BSB, 32'h0, "reset_busy_b");
    exp_now(K_ERR, 32'h0, "reset_err");

    // Write then read
    write(16'h0020, 32'hDEADBEEF);
    tick();
    idle(); rd_a_sel = 4'd5; rd_b_sel = 4'd0;
    exp_next(K_RDA, 32'hDEADBEEF, "wr_rd_r5");
    exp_next(K_RDB, 32'h0, "wr_rd_r0");
    tick();

    // Write-through bypass on register 8
    write(16'h0100, 32'h11111111);
    tick();
    write(16'h0100, 32'h12345678); rd_a_sel = 4'd8; rd_b_sel = 4'd5;
    exp_next(K_RDA, 32'h12345678, "bypass_r8");
    exp_next(K_RDB, 32'hDEADBEEF, "bypass_other_port_r5");
    tick();
    idle();
    exp_next(K_RDA, 32'h12345678, "after_bypass_r8");
    tick();

    // Claim / pending on register 3
    claim_en = 1'b1; claim_sel = 4'd3; rd_a_sel = 4'd3; rd_b_sel = 4'd3;
    exp_now(K_BSA, 32'h0, "claim_no_bypass");
    tick();
    idle();
    exp_now(K_BSA, 32'h1, "claim_busy_a");
    exp_now(K_BSB, 32'h1, "claim_busy_b");
    write(16'h0008, 32'h00000033);
    exp_next(K_RDA, 32'h00000033, "wb_r3_data");
    exp_next(K_BSA, 32'h0, "wb_clears_busy");
    tick();
    idle();
    claim_en = 1'b1; claim_sel = 4'd3; write(16'h0008, 32'h00000044);
    exp_next(K_RDA, 32'h00000044, "claim_wr_data");
    exp_next(K_BSA, 32'h1, "claim_wins");
    tick();
    idle();
    tick();

    // Register 0 hardwired
    write(16'h0001, 32'hAAAA5555); rd_a_sel = 4'd0;
    exp_next(K_RDA, 32'h0, "r0_write_through");
    exp_next(K_ERR, 32'h0, "r0_no_err");
    tick();
    idle(); claim_en = 1'b1; claim_sel = 4'd0;
    exp_next(K_RDA, 32'h0, "r0_reads_zero");
    tick();
    idle();
    exp_now(K_BSA, 32'h0, "r0_claim_busy");
    tick();

    // Illegal selects
    write(16'h0002, 32'h01010101);
    tick();
    write(16'h0004, 32'h02020202);
    tick();
    idle(); wr_sel = 16'h00FF; wr_data = 32'h00000BAD; rd_a_sel = 4'd1; rd_b_sel = 4'd2;
    exp_next(K_ERR, 32'h0, "wr_en0_no_err");
    exp_next(K_RDA, 32'h01010101, "wr_en0_r1");
    tick();
    write(16'h0000, 32'h00000BAD);
    exp_next(K_RDB, 32'h02020202, "sel0_r2");
    exp_next(K_ERR, 32'h0, "sel0_no_err");
    tick();
    write(16'h0006, 32'hFFFFFFFF);
    exp_next(K_RDA, 32'h01010101, "illegal_r1");
    exp_next(K_RDB, 32'h02020202, "illegal_r2");
    exp_next(K_ERR, 32'h1, "illegal_err");
    tick();
    n_cmp++;
    if (err_sel !== 1'b1) begin
      n_bad++;
      $display("FAIL direct_illegal_err: got %b expected %b", err_sel, 1'b1);
    end
    n_cmp++;
    if (rd_a_data !== 32'h01010101) begin
      n_bad++;
      $display("FAIL direct_illegal_r1: got %h expected %h", rd_a_data, 32'h01010101);
    end
    write(16'h0040, 32'h00000066); rd_b_sel = 4'd6;
    exp_next(K_ERR, 32'h1, "err_sticky");
    exp_next(K_RDA, 32'h01010101, "illegal_r1_held");
    exp_next(K_RDB, 32'h00000066, "legal_after_err");
    tick();
    idle();
    tick();

    // Reset mid-operation
    claim_en = 1'b1; claim_sel = 4'd4;
    tick();
    claim_sel = 4'd9;
    tick();
    idle(); write(16'h0080, 32'h00000077); rd_a_sel = 4'd4; rd_b_sel = 4'd9;
    exp_now(K_BSA, 32'h1, "pre_reset_busy4");
    exp_now(K_BSB, 32'h1, "pre_reset_busy9");
    tick();
    idle(); reset = 1'b1;
    claim_en = 1'b1; claim_sel = 4'd5; write(16'h0400, 32'h00000ABC);
    tick();
    reset = 1'b0; idle();
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_post_reset_busy4: got %b expected %b", busy_a, 1'b0);
    end
    n_cmp++;
    if (busy_b !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_post_reset_busy9: got %b expected %b", busy_b, 1'b0);
    end
    n_cmp++;
    if (rd_a_data !== 32'h0) begin
      n_bad++;
      $display("FAIL direct_post_reset_rd_a: got %h expected %h", rd_a_data, 32'h0);
    end
    n_cmp++;
    if (err_sel !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_post_reset_err: got %b expected %b", err_sel, 1'b0);
    end
    exp_now(K_BSA, 32'h0, "post_reset_busy4");
    exp_now(K_BSB, 32'h0, "post_reset_busy9");
    exp_now(K_ERR, 32'h0, "post_reset_err");
    exp_now(K_RDA, 32'h0, "post_reset_rd_a");
    exp_now(K_RDB, 32'h0, "post_reset_rd_b");
    rd_a_sel = 4'd7; rd_b_sel = 4'd10;
    exp_next(K_RDA, 32'h0, "post_reset_r7");
    exp_next(K_RDB, 32'h0, "reset_drops_write_r10");
    tick();
    rd_a_sel = 4'd3; rd_b_sel = 4'd5;
    exp_now(K_BSA, 32'h0, "post_reset_busy3");
    exp_now(K_BSB, 32'h0, "reset_drops_claim5");
    rd_a_sel = 4'd3;
    tick();
    rd_a_sel = 4'd6;
    exp_next(K_RDA, 32'h0, "post_reset_r6");
    tick();

    repeat (3) tick();
    foreach (sb[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got unchecked expected checked", sb[i].name);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_16x32.md
REGFILE_16X32 -- requirements
Module: regfile_16x32

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each register and of every data port.
REQ-002 SHALL have parameter R0_ZERO, default 1: 1 makes register 0 hardwired to zero; 0 makes it an ordinary register.
REQ-003 SHALL have `clock` (in, 1): the single clock; all state updates on its rising edge.
REQ-004 SHALL have `reset` (in, 1): reset, synchronous and active-high.
REQ-005 SHALL have `wr_en` (in, 1): write-back strobe.
REQ-006 SHALL have `wr_sel` (in, 16): one-hot destination select, driven from the 4-to-16 decoder output; bit i selects register i.
REQ-007 SHALL have `wr_data` (in, DATA_W): write-back value.
REQ-008 SHALL have `claim_en` (in, 1): issue strobe that marks a destination as pending.
REQ-009 SHALL have `claim_sel` (in, 4): binary index of the register being claimed.
REQ-010 SHALL have `rd_a_sel` and `rd_b_sel` (in, 4 each): binary read indices.
REQ-011 SHALL have `rd_a_data` and `rd_b_data` (out, DATA_W each): registered read data.
REQ-012 SHALL have `busy_a` and `busy_b` (out, 1 each): pending status of the register currently addressed by `rd_a_sel` / `rd_b_sel`.
REQ-013 SHALL have `err_sel` (out, 1): sticky flag for an illegal `wr_sel` pattern.

Function
REQ-014 SHALL hold 16 registers of DATA_W bits and a 16-bit pending vector.
- Write commit:
  - REQ-015 SHALL commit a write at the edge when `wr_en`=1 and `wr_sel` has exactly one bit set: register[i] <= `wr_data` and pending[i] <= 0.
  - REQ-016 SHALL leave the register file and pending vector unchanged when `wr_en`=1 and `wr_sel`=0.
  - REQ-017 SHALL suppress the write entirely when `wr_en`=1 and `wr_sel` has two or more bits set, and SHALL set `err_sel` <= 1.
  - REQ-018 SHALL ignore `wr_sel` completely when `wr_en`=0, including for `err_sel` purposes.
- Register 0:
  - REQ-019 With R0_ZERO=1, a write to register 0 SHALL be discarded, register 0 SHALL read as 0, pending[0] SHALL never set, and this case SHALL NOT be an error.
- Claim and pending:
  - REQ-020 SHALL set pending[`claim_sel`] <= 1 at the edge when `claim_en`=1.
  - REQ-021 When a claim and a legal write hit the same register in the same cycle, the write data SHALL commit and pending SHALL end at 1 (claim wins).
- Read ports:
  - REQ-022 Read latency SHALL be 1 cycle: `rd_x_data` at edge N+1 = register[`rd_x_sel` sampled at N].
  - REQ-023 Reads SHALL be write-through: if a legal write to the same index commits at that edge, `rd_x_data` SHALL take `wr_data` (except register 0 with R0_ZERO=1, which reads 0).
  - REQ-024 Both read ports SHALL be independent and may address the same register.
- Busy outputs:
  - REQ-025 `busy_x` SHALL be combinational = pending[`rd_x_sel`] from the registered pending vector, with no bypass of same-cycle claim or write.
- Error flag:
  - REQ-026 `err_sel` SHALL remain 1 until reset.

Reset
REQ-027 While `reset`=1 at an edge, all registers, the pending vector, `rd_a_data`, `rd_b_data` and `err_sel` SHALL become 0, and `busy_a`/`busy_b` SHALL read 0 after that edge.
REQ-028 Reset SHALL take priority over any simultaneous write or claim, and those operations SHALL be lost.
REQ-029 Reset asserted mid-sequence SHALL clear all pending bits, with no write needed afterwards.

Verification
REQ-030 Write then read: reset; `wr_en`=1, `wr_sel`=0x0020, `wr_data`=0xDEADBEEF; next cycle `rd_a_sel`=5 -> `rd_a_data`=0xDEADBEEF one cycle later; `rd_b_sel`=0 -> 0.
REQ-031 Bypass: same cycle write `wr_sel`=0x0100, `wr_data`=0x12345678 with `rd_a_sel`=8 -> `rd_a_data`=0x12345678 after that edge, not the old value.
REQ-032 Scoreboard: `claim_en`=1, `claim_sel`=3 -> `busy_a`=1 with `rd_a_sel`=3 from the next cycle; write `wr_sel`=0x0008 -> `busy_a`=0 after the edge; simultaneous claim and write on 3 -> `busy_a` stays 1.
REQ-033 Illegal select: `wr_en`=1, `wr_sel`=0x0006, `wr_data`=0xFFFFFFFF -> registers 1 and 2 unchanged and `err_sel`=1, held across later legal writes; `wr_en`=0 with `wr_sel`=0x00FF -> no error.
REQ-034 R0: write `wr_sel`=0x0001, `wr_data`=0xAAAA5555 -> register 0 reads 0 and `err_sel`=0; `claim_sel`=0 -> `busy`=0.
REQ-035 Reset mid-operation: claims on 4 and 9 plus a written register 7, then `reset` for 1 cycle -> all reads 0, `busy`=0, `err_sel`=0.
